parallel_to_serial: RTL and testbench

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/parallel_to_serial.sv | 121 ++++++++++++
 tb/tb_parallel_to_serial.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// Serializes a parallel address/data pair LSB first under a ctrl frame strobe.
// Optional one-entry request queue: define P2S_QUEUE_EN.
module parallel_to_serial #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16,
   parameter int GAP    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              addr_ser,
   output logic              data_ser,
   output logic              ctrl,
   output logic              done
);

   localparam int CNT_W = $clog2(ADDR_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr_sr;
   logic [DATA_W-1:0] data_sr;
   logic [CNT_W-1:0]  bit_cnt;
   logic [3:0]        gap_cnt;
   logic              accept;
   logic              last_bit;
   logic              last_gap;
   logic              load_hold;

   assign last_bit = (state == ST_SHIFT) && (bit_cnt == CNT_W'(ADDR_W - 1));
   assign last_gap = (state == ST_GAP) && (gap_cnt == 4'(GAP - 1));

`ifdef P2S_QUEUE_EN
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;
   logic              full;
   logic              capture;

   // Busy-time requests park in the holding register until the gap expires.
   assign accept    = start && !full && (state == ST_IDLE);
   assign capture   = start && !full && (state != ST_IDLE);
   assign load_hold = last_gap && full;
   assign ready     = !full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_addr <= '0;
         hold_data <= '0;
         full      <= 1'b0;
      end else if (capture) begin
         hold_addr <= addr_in;
         hold_data <= data_in;
         full      <= 1'b1;
      end else if (load_hold) begin
         full      <= 1'b0;
      end
   end
`else
   assign accept    = start && (state == ST_IDLE);
   assign load_hold = 1'b0;
   assign ready     = (state == ST_IDLE);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (accept)   state_next = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_next = ST_GAP;
         ST_GAP:   if (last_gap) state_next = load_hold ? ST_SHIFT : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_sr <= '0;
         data_sr <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         done    <= 1'b0;
      end else begin
         done <= last_bit;
         if (accept) begin
            addr_sr <= addr_in;
            data_sr <= data_in;
            bit_cnt <= '0;
`ifdef P2S_QUEUE_EN
         end else if (load_hold) begin
            addr_sr <= hold_addr;
            data_sr <= hold_data;
            bit_cnt <= '0;
`endif
         end else if (state == ST_SHIFT) begin
            addr_sr <= addr_sr >> 1;
            data_sr <= data_sr >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
         end
         if (last_bit)              gap_cnt <= '0;
         else if (state == ST_GAP)  gap_cnt <= gap_cnt + 4'd1;
      end
   end

   // Serial outputs are gated by state so reset clears them without a clock.
   assign ctrl     = (state == ST_SHIFT);
   assign addr_ser = ctrl & addr_sr[0];
   assign data_ser = ctrl & data_sr[0];

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed + randomized bench for parallel_to_serial; honours P2S_QUEUE_EN if defined.
module tb_parallel_to_serial;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int GP = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] data_in;
   logic          ready, addr_ser, data_ser, ctrl, done;

   int checks = 0;
   int errors = 0;
   logic [AW-1:0] inj_a;
   logic [DW-1:0] inj_d;

   parallel_to_serial #(.ADDR_W(AW), .DATA_W(DW), .GAP(GP)) dut (
      .clk(clk), .rst(rst), .start(start), .addr_in(addr_in), .data_in(data_in),
      .ready(ready), .addr_ser(addr_ser), .data_ser(data_ser), .ctrl(ctrl), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called at a negedge while idle; returns at the negedge of frame cycle 0.
   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk("ready_before_start", ready, 1);
      start   = 1'b1;
      addr_in = a;
      data_in = d;
      @(negedge clk);
      start   = 1'b0;
      addr_in = AW'($urandom);
      data_in = DW'($urandom);
   endtask

   // Expected frame: bit n of a on addr_ser, bit n of d (or 0 past DW) on data_ser.
   // inj >= 0 raises a second start during cycle inj; ncyc < AW stops early.
   task automatic check_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int inj, input int ncyc);
      logic exp_d;
      logic exp_rdy;
      for (int n = 0; n < ncyc; n++) begin
         exp_d = 1'b0;
         if (n < DW) exp_d = d[n];
`ifdef P2S_QUEUE_EN
         exp_rdy = (inj >= 0 && n > inj) ? 1'b0 : 1'b1;
`else
         exp_rdy = 1'b0;
`endif
         chk("ctrl_frame", ctrl, 1);
         chk("addr_ser_bit", addr_ser, a[n]);
         chk("data_ser_bit", data_ser, exp_d);
         chk("done_in_frame", done, 0);
         chk("ready_in_frame", ready, exp_rdy);
         if (n == inj) begin
            start   = 1'b1;
            addr_in = inj_a;
            data_in = inj_d;
         end else if (inj >= 0 && n == inj + 1) begin
            start   = 1'b0;
            addr_in = AW'($urandom);
            data_in = DW'($urandom);
         end
         if (n == ncyc - 1 && ncyc < AW) return;
         @(negedge clk);
      end
      for (int g = 0; g < GP; g++) begin
`ifdef P2S_QUEUE_EN
         exp_rdy = (inj >= 0) ? 1'b0 : 1'b1;
`else
         exp_rdy = 1'b0;
`endif
         chk("ctrl_gap", ctrl, 0);
         chk("addr_ser_gap", addr_ser, 0);
         chk("data_ser_gap", data_ser, 0);
         chk("done_gap", done, (g == 0) ? 1 : 0);
         chk("ready_gap", ready, exp_rdy);
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk("ctrl_idle", ctrl, 0);
         chk("done_idle", done, 0);
         chk("ready_idle", ready, 1);
         chk("addr_ser_idle", addr_ser, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      rst = 1'b1; start = 1'b0; addr_in = '0; data_in = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_addr_ser", addr_ser, 0);
      chk("rst_data_ser", data_ser, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;

      // First edge after reset release must accept.
      send(20'h003FF, 16'h03FF);
      check_frame(20'h003FF, 16'h03FF, -1, AW);
      check_idle(1);

      send(20'hA5A5A, 16'h8001);
      check_frame(20'hA5A5A, 16'h8001, -1, AW);
      check_idle(1);

      for (int k = 0; k < 5; k++) begin
         ra = AW'($urandom);
         rd = DW'($urandom);
         send(ra, rd);
         check_frame(ra, rd, -1, AW);
         check_idle(1 + int'($urandom_range(0, 2)));
      end

      // Start during a frame: ignored, or queued when the holding register exists.
      ra = AW'($urandom);
      rd = DW'($urandom);
      inj_a = ~ra;
      inj_d = ~rd;
      send(ra, rd);
      check_frame(ra, rd, 5, AW);
`ifdef P2S_QUEUE_EN
      check_frame(inj_a, inj_d, -1, AW);
`endif
      check_idle(AW + 4);

      // Asynchronous reset in frame cycle 10.
      send(20'hFFFFF, 16'hFFFF);
      check_frame(20'hFFFFF, 16'hFFFF, -1, 11);
      #2 rst = 1'b0;
      #1;
      chk("async_ctrl", ctrl, 0);
      chk("async_addr_ser", addr_ser, 0);
      chk("async_data_ser", data_ser, 0);
      chk("async_ready", ready, 1);
      chk("async_done", done, 0);
      @(negedge clk);
      chk("rst_hold_done", done, 0);
      rst = 1'b1;
      check_idle(2);
      ra = AW'($urandom);
      rd = DW'($urandom);
      send(ra, rd);
      check_frame(ra, rd, -1, AW);
      check_idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
